// File: rtl/wasm_pkg.sv
// Shared constants for the wasm core: const opcodes, trap codes, fetch FSM encoding.
// Also holds the per-mode immediate byte limits and the window length helper.
package wasm_pkg;

   localparam logic [7:0] OP_I32_CONST = 8'h41;
   localparam logic [7:0] OP_I64_CONST = 8'h42;
   localparam logic [7:0] OP_F32_CONST = 8'h43;
   localparam logic [7:0] OP_F64_CONST = 8'h44;

   localparam logic [3:0] TRAP_NONE   = 4'd0;
   localparam logic [3:0] TRAP_MEM    = 4'd1;
   localparam logic [3:0] TRAP_LEB    = 4'd2;
   localparam logic [3:0] TRAP_OPCODE = 4'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA, ST_DONE} state_t;
   typedef enum logic [1:0] {MODE_I32, MODE_I64, MODE_F32, MODE_F64} mode_t;

   // Raw modes need exactly this many bytes; LEB modes need at most this many.
   function automatic logic [3:0] max_bytes(input mode_t m);
      case (m)
         MODE_I32: max_bytes = 4'd5;
         MODE_I64: max_bytes = 4'd10;
         MODE_F32: max_bytes = 4'd4;
         default:  max_bytes = 4'd8;
      endcase
   endfunction

   function automatic logic [4:0] win_len(input logic [3:0] rem, input logic [4:0] w);
      win_len = (5'(rem) < w) ? 5'(rem) : w;
   endfunction

endpackage

// File: rtl/leb128_window.sv
// Combinational LEB128 scan of one fetch window; stops at the first byte with bit7 clear.
// Payload is packed from bit 0 of the window; the caller shifts it into place.
module leb128_window #(
   parameter int W = 16
) (
   input  logic [W*8-1:0] win_data,
   input  logic [4:0]     valid_cnt,
   input  logic [3:0]     max_rem,
   output logic [7*W-1:0] payload,
   output logic [4:0]     consumed,
   output logic           terminated,
   output logic [7:0]     last_byte
);

   logic       stop;
   logic [7:0] cur;

   always_comb begin
      payload    = '0;
      consumed   = 5'd0;
      terminated = 1'b0;
      last_byte  = 8'd0;
      stop       = 1'b0;
      cur        = 8'd0;
      for (int j = 0; j < W; j++) begin
         if (!stop && (5'(j) < valid_cnt) && (5'(j) < 5'(max_rem))) begin
            cur                = win_data[W*8-1-8*j -: 8];
            payload[7*j +: 7]  = cur[6:0];
            consumed           = 5'(j + 1);
            last_byte          = cur;
            if (!cur[7]) begin
               terminated = 1'b1;
               stop       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/const_fetch.sv
// Multi-cycle immediate fetch for i32/i64/f32/f64.const over a windowed ROM port.
// LEB immediates are decoded window by window; float immediates are copied little-endian.
module const_fetch #(
   parameter int MEM_DEPTH = 4,
   parameter int MEM_EXTRA = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [7:0]                    opcode,
   input  logic [MEM_DEPTH:0]            pc,
   output logic                          busy,
   output logic                          done,
   output logic [63:0]                   value,
   output logic [MEM_DEPTH:0]            next_pc,
   output logic [3:0]                    trap,
   output logic [MEM_DEPTH:0]            mem_addr,
   output logic [MEM_EXTRA-1:0]          mem_extra,
   input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
   input  logic                          mem_error,
   output logic [1:0]                    dbg_state
);
   import wasm_pkg::*;

   localparam int AW = MEM_DEPTH + 1;
   localparam int W  = 2**MEM_EXTRA;
   localparam logic [4:0] W5 = 5'(W);

   state_t         state_q, state_d;
   mode_t          mode_q, mode_d;
   logic [AW-1:0]  pc_q, pc_d, addr_q, addr_d;
   logic [3:0]     rem_q, rem_d, cnt_q, cnt_d;
   logic [63:0]    acc_q, acc_d, value_q, value_d;
   logic [AW-1:0]  next_pc_q, next_pc_d, mem_addr_q, mem_addr_d;
   logic [3:0]     trap_q, trap_d;
   logic           done_q, done_d, busy_q, busy_d;
   logic [MEM_EXTRA-1:0] mem_extra_q, mem_extra_d;

   logic           op_known;
   mode_t          op_mode;
   logic [4:0]     win_cnt;
   logic [7*W-1:0] leb_payload;
   logic [4:0]     leb_consumed;
   logic           leb_term;
   logic [7:0]     leb_last;

   assign win_cnt = 5'(mem_extra_q) + 5'd1;

   leb128_window #(.W(W)) u_leb (
      .win_data   (mem_data),
      .valid_cnt  (win_cnt),
      .max_rem    (rem_q),
      .payload    (leb_payload),
      .consumed   (leb_consumed),
      .terminated (leb_term),
      .last_byte  (leb_last)
   );

   always_comb begin
      op_known = 1'b1;
      op_mode  = MODE_I32;
      case (opcode)
         OP_I32_CONST: op_mode = MODE_I32;
         OP_I64_CONST: op_mode = MODE_I64;
         OP_F32_CONST: op_mode = MODE_F32;
         OP_F64_CONST: op_mode = MODE_F64;
         default:      op_known = 1'b0;
      endcase
   end

   // Raw bytes land at byte lanes cnt_q.. of the accumulator.
   logic [63:0] raw_acc;
   always_comb begin
      raw_acc = acc_q;
      for (int j = 0; j < W; j++) begin
         for (int p = 0; p < 8; p++) begin
            if ((5'(j) < win_cnt) && (5'(p) == 5'(cnt_q) + 5'(j)))
               raw_acc[8*p +: 8] = mem_data[W*8-1-8*j -: 8];
         end
      end
   end

   logic        is_raw, is32, at_max, high_bad, leb_trap, finished;
   logic [6:0]  sh, bits_total, width_bits;
   logic [4:0]  step_n, cnt_new;
   logic [3:0]  rem_new;
   logic [63:0] leb_acc, leb_val, fill;

   always_comb begin
      is_raw     = (mode_q == MODE_F32) || (mode_q == MODE_F64);
      is32       = (mode_q == MODE_I32);
      sh         = 7'(cnt_q) * 7'd7;
      leb_acc    = acc_q | 64'({64'd0, leb_payload} << sh);
      step_n     = is_raw ? win_cnt : leb_consumed;
      rem_new    = rem_q - 4'(step_n);
      cnt_new    = 5'(cnt_q) + step_n;
      bits_total = 7'(cnt_new) * 7'd7;
      width_bits = is32 ? 7'd32 : 7'd64;
      fill       = (leb_last[6] && (bits_total < width_bits)) ? (~64'd0 << bits_total) : 64'd0;
      leb_val    = leb_acc | fill;
      if (is32) leb_val[63:32] = 32'd0;
      // Bits of the last allowed byte above the value width must replicate the sign.
      high_bad   = is32 ? (leb_last[6:4] != {3{leb_last[3]}})
                        : (leb_last[6:1] != {6{leb_last[0]}});
      at_max     = (cnt_new == 5'(max_bytes(mode_q)));
      leb_trap   = leb_term ? (at_max && high_bad) : (rem_new == 4'd0);
      finished   = is_raw ? (rem_new == 4'd0) : (leb_term || (rem_new == 4'd0));
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      value_d     = value_q;
      next_pc_d   = next_pc_q;
      trap_d      = trap_q;
      done_d      = 1'b0;
      busy_d      = busy_q;
      mem_addr_d  = mem_addr_q;
      mem_extra_d = mem_extra_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               pc_d   = pc;
               addr_d = pc;
               cnt_d  = 4'd0;
               acc_d  = 64'd0;
               mode_d = op_mode;
               if (!op_known) begin
                  state_d   = ST_DONE;
                  done_d    = 1'b1;
                  trap_d    = TRAP_OPCODE;
                  value_d   = 64'd0;
                  next_pc_d = pc;
               end else begin
                  state_d     = ST_REQ;
                  rem_d       = max_bytes(op_mode);
                  mem_addr_d  = pc;
                  mem_extra_d = MEM_EXTRA'(win_len(max_bytes(op_mode), W5) - 5'd1);
               end
            end
         end
         ST_REQ: state_d = ST_DATA;
         ST_DATA: begin
            if (mem_error) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               trap_d    = TRAP_MEM;
               value_d   = 64'd0;
               next_pc_d = pc_q;
            end else if (finished) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               next_pc_d = pc_q + AW'(cnt_new);
               if (!is_raw && leb_trap) begin
                  trap_d  = TRAP_LEB;
                  value_d = 64'd0;
               end else begin
                  trap_d  = TRAP_NONE;
                  value_d = is_raw ? raw_acc : leb_val;
               end
            end else begin
               state_d     = ST_REQ;
               acc_d       = is_raw ? raw_acc : leb_acc;
               cnt_d       = 4'(cnt_new);
               rem_d       = rem_new;
               addr_d      = addr_q + AW'(step_n);
               mem_addr_d  = addr_q + AW'(step_n);
               mem_extra_d = MEM_EXTRA'(win_len(rem_new, W5) - 5'd1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_I32;
         pc_q        <= '0;
         addr_q      <= '0;
         rem_q       <= 4'd0;
         cnt_q       <= 4'd0;
         acc_q       <= 64'd0;
         value_q     <= 64'd0;
         next_pc_q   <= '0;
         trap_q      <= 4'd0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_extra_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         value_q     <= value_d;
         next_pc_q   <= next_pc_d;
         trap_q      <= trap_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         mem_addr_q  <= mem_addr_d;
         mem_extra_q <= mem_extra_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign value     = value_q;
   assign next_pc   = next_pc_q;
   assign trap      = trap_q;
   assign mem_addr  = mem_addr_q;
   assign mem_extra = mem_extra_q;
   assign dbg_state = state_q;

endmodule
